// File: rtl/interconexion_pio_pkg.sv
// rtl/interconexion_pio_pkg.sv - shared register map and edge-type encodings for interconexion PIO blocks
package interconexion_pio_pkg;

   localparam logic [1:0] ADDR_DATA     = 2'd0;
   localparam logic [1:0] ADDR_IRQ_MASK = 2'd1;
   localparam logic [1:0] ADDR_EDGE_CAP = 2'd2;

   localparam int EDGE_RISING  = 0;
   localparam int EDGE_FALLING = 1;
   localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/interconexion_pio_in_if.sv
// rtl/interconexion_pio_in_if.sv - s1-style slave bus with interrupt line for the input PIO
interface interconexion_pio_in_if;

   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata, irq
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata, irq
   );

endinterface

// File: rtl/interconexion_sync_chain.sv
// rtl/interconexion_sync_chain.sv - multi-flop synchronizer for an asynchronous input bus
module interconexion_sync_chain #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage_q [SYNC_STAGES];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= d;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/interconexion_pio_in.sv
// rtl/interconexion_pio_in.sv - input PIO with edge capture and maskable irq; PIO_IN_BIT_CLEAR_EN selects per-bit capture clear
module interconexion_pio_in
   import interconexion_pio_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int EDGE_TYPE   = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   reset_n,
   interconexion_pio_in_if.slave  s1,
   input  logic [WIDTH-1:0]       in_port
);

   logic [WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] irq_mask_q;
   logic [WIDTH-1:0] edge_cap_q;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] clr_mask;
   logic             wr_en;

   interconexion_sync_chain #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (in_port),
      .q       (sync_q)
   );

   assign wr_en = s1.chipselect && !s1.write_n;

   always_comb begin
      edge_det = '0;
      case (EDGE_TYPE)
         EDGE_RISING:  edge_det = sync_q & ~prev_q;
         EDGE_FALLING: edge_det = ~sync_q & prev_q;
         default:      edge_det = sync_q ^ prev_q;
      endcase
   end

   always_comb begin
      clr_mask = '0;
      if (wr_en && s1.address == ADDR_EDGE_CAP) begin
`ifdef PIO_IN_BIT_CLEAR_EN
         clr_mask = s1.writedata[WIDTH-1:0];
`else
         clr_mask = '1;
`endif
      end
   end

   // Edge set is OR-ed after the clear so a coincident edge is never lost.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_q     <= '0;
         irq_mask_q <= '0;
         edge_cap_q <= '0;
      end else begin
         prev_q     <= sync_q;
         edge_cap_q <= (edge_cap_q & ~clr_mask) | edge_det;
         if (wr_en && s1.address == ADDR_IRQ_MASK) begin
            irq_mask_q <= s1.writedata[WIDTH-1:0];
         end
      end
   end

   always_comb begin
      s1.readdata = '0;
      case (s1.address)
         ADDR_DATA:     s1.readdata = 32'(sync_q);
         ADDR_IRQ_MASK: s1.readdata = 32'(irq_mask_q);
         ADDR_EDGE_CAP: s1.readdata = 32'(edge_cap_q);
         default:       s1.readdata = '0;
      endcase
   end

   assign s1.irq = |(edge_cap_q & irq_mask_q);

endmodule
